mult_share_arbiter: RTL
=======================

Name: mult_share_arbiter

Overview:
- Shares one sequential sign-magnitude fractional multiplier (7-bit operands, 13-bit product, start/done handshake) between NUM_REQ requesters.
- Uses round-robin arbitration. Latches the winner's operands, sequences the multiplier's start/done protocol, and returns the product to the winner with a one-cycle ack.
- Sits between requesting datapath units and a single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 32, cycles allowed from m_start to m_done; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NUM_REQ  per-requester request level.
- a_in  in  NUM_REQ*7  operand a, requester i at bits [7i+6:7i].
- b_in  in  NUM_REQ*7  operand b, same packing.
- ack  out  NUM_REQ  one-hot, one-cycle pulse when the result for requester i is valid.
- result  out  13  last delivered product.
- result_id  out  3  index of the last delivered requester.
- busy  out  1  high whenever state != IDLE.
- m_start  out  1  multiplier start pulse.
- m_a  out  7  multiplier operand a.
- m_b  out  7  multiplier operand b.
- m_done  in  1  multiplier done level.
- m_product  in  13  multiplier product.
- err  out  1  timeout flag; tied to 0 when the optional feature is off.

Behaviour:
- Reset (rst_n=0 at posedge) clears: state=IDLE, ack=0, result=0, result_id=0, m_start=0, m_a=0, m_b=0, err=0, rr pointer=0 (requester 0 has highest priority).
- Reset asserted mid-operation abandons the operation; no ack is issued.
- FSM states: IDLE, LAUNCH, ARM, WAIT, DELIVER.
- IDLE:
  - If any req bit is set, pick the winner g: the first set bit searching from ptr upward, wrapping.
  - Latch m_a/m_b from that requester's slices and record g.
  - Go to LAUNCH.
- LAUNCH: m_start=1 for exactly this one cycle, then go to ARM.
- ARM:
  - Wait for m_done==0, so a stale done left from the previous operation is ignored.
  - Once m_done==0 is seen, go to WAIT.
  - If m_done is already 0 on entry, this costs one cycle.
- WAIT: on m_done==1, capture m_product into result, set result_id=g, go to DELIVER.
- DELIVER:
  - ack[g]=1 for one cycle.
  - ptr=(g+1) mod NUM_REQ.
  - Go to IDLE.
- Latency: grant to ack = multiplier latency + 4 cycles minimum.
- Back-to-back: the IDLE cycle after DELIVER re-arbitrates; there is no bubble beyond that cycle.
- Requester protocol:
  - Hold req and operands stable until ack.
  - Drop req in the cycle after ack, or keep it high to issue another operation.
  - A requester that keeps req high does not starve the others, because of round-robin.
- Operands are sampled only in IDLE. Changes to req, a_in or b_in after the grant are ignored until the next arbitration.
- A req deasserted after its grant still completes; ack is still pulsed.
- m_a/m_b stay held until the next grant; the multiplier may rely on them across the whole operation.
- result and result_id hold their values until the next DELIVER.
- No arithmetic is done here: product width, sign and fractional semantics are the multiplier's.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- Defined:
  - A counter clears in LAUNCH and counts each cycle in ARM/WAIT.
  - When the count reaches TIMEOUT without a DELIVER, the arbiter forces result=13'h0 and result_id=g, sets err=1 (sticky until reset), pulses ack[g], advances ptr, and returns to IDLE.
- Undefined: the counter is absent, err is tied to 0, and the arbiter waits forever.

Decomposition:
- Package mult_arb_pkg:
  - OP_W=7, PROD_W=13, ID_W=3.
  - State enum encodings IDLE=0, LAUNCH=1, ARM=2, WAIT=3, DELIVER=4.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: grant index and a valid flag.
  - Instantiated once; ptr register lives in the parent.

Test Plan:
- Bench model: a behavioural multiplier with product={a[6]^b[6], a[5:0]*b[5:0]} and 6-cycle latency.
- Single request: req=4'b0001, a0=7'b0000100, b0=7'b0000010 -> one m_start pulse, ack=4'b0001, result=13'h0008, result_id=0.
- Sign case: req=4'b0100, a2=7'b1000011, b2=7'b0000101 -> result=13'h100F, result_id=2, busy low after DELIVER.
- Fairness: all four req held high, every product distinct -> ack order 0,1,2,3,0,1; no requester acked twice before the others.
- Stale done: m_done left high after an operation, new req arrives -> arbiter stays in ARM until m_done falls; no early ack and no wrong result.
- Reset mid-WAIT: rst_n=0 for one cycle during WAIT -> all outputs 0, no ack, next request served by requester-0 priority.
- With MULT_TIMEOUT_EN and TIMEOUT=32: model never raises done -> ack pulses 33 cycles after m_start, result=0, err=1 sticky.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared widths, FSM state encoding and a small helper for the
// mult_share_arbiter block.
//   OP_W   - multiplier operand width
//   PROD_W - multiplier product width
//   ID_W   - width of a requester index
package mult_arb_pkg;

    localparam int OP_W   = 7;
    localparam int PROD_W = 13;
    localparam int ID_W   = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        ARM     = 3'd2,
        WAIT    = 3'd3,
        DELIVER = 3'd4
    } arb_state_t;

    // Next round-robin pointer after serving requester id.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id,
                                                input int num_req);
        return (int'(id) == num_req - 1) ? {ID_W{1'b0}} : id + {{(ID_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   - request vector
//   ptr   - index with highest priority this round
//   grant - index of the first set request at or above ptr, wrapping
//   valid - at least one request is set
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               valid
);

    logic [ID_W-1:0] grant_s;
    logic            valid_s;
    int              idx_s;

    // Scan from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin
        grant_s = {ID_W{1'b0}};
        valid_s = 1'b0;
        idx_s   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_s   = (int'(ptr) + k) % NUM_REQ;
            grant_s = req[idx_s] ? ID_W'(idx_s) : grant_s;
            valid_s = valid_s | req[idx_s];
        end
    end

    assign grant = grant_s;
    assign valid = valid_s;

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one sequential multiplier between NUM_REQ
// requesters using round-robin arbitration.
//   req/a_in/b_in   - per-requester request level and packed operands
//   ack             - one-hot, one-cycle pulse when requester's result is valid
//   result/result_id- last delivered product and its requester index
//   busy            - high whenever the FSM is not idle
//   m_start/m_a/m_b - multiplier launch pulse and held operands
//   m_done/m_product- multiplier done level and product
//   err             - sticky timeout flag
// Optional feature macro: MULT_TIMEOUT_EN (operation timeout after TIMEOUT
// cycles; when undefined err is tied low and the arbiter waits forever).
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*OP_W-1:0] a_in,
    input  logic [NUM_REQ*OP_W-1:0] b_in,
    output logic [NUM_REQ-1:0]      ack,
    output logic [PROD_W-1:0]       result,
    output logic [ID_W-1:0]         result_id,
    output logic                    busy,
    output logic                    m_start,
    output logic [OP_W-1:0]         m_a,
    output logic [OP_W-1:0]         m_b,
    input  logic                    m_done,
    input  logic [PROD_W-1:0]       m_product,
    output logic                    err
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t          state_r;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     gnt_r;
    logic [NUM_REQ-1:0]  ack_r;
    logic [PROD_W-1:0]   result_r;
    logic [ID_W-1:0]     result_id_r;
    logic                busy_r;
    logic                m_start_r;
    logic [OP_W-1:0]     m_a_r;
    logic [OP_W-1:0]     m_b_r;
    logic [ID_W-1:0]     pick_id_s;
    logic                pick_valid_s;
    logic                tmo_hit_s;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .grant (pick_id_s),
        .valid (pick_valid_s)
    );

`ifdef MULT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    // Timeout fires on the cycle the count would reach TIMEOUT; a real done in
    // WAIT on that same cycle takes precedence.
    assign tmo_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1)) &&
                       ((state_r == ARM) || ((state_r == WAIT) && !m_done));

    // Operation cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            err_r <= 1'b0;
        end else begin
            if (state_r == LAUNCH) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == ARM) || (state_r == WAIT)) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            err_r <= err_r | tmo_hit_s;
        end
    end

    assign err = err_r;
`else
    assign tmo_hit_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Arbitration / multiplier sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= {ID_W{1'b0}};
            gnt_r       <= {ID_W{1'b0}};
            ack_r       <= {NUM_REQ{1'b0}};
            result_r    <= {PROD_W{1'b0}};
            result_id_r <= {ID_W{1'b0}};
            busy_r      <= 1'b0;
            m_start_r   <= 1'b0;
            m_a_r       <= {OP_W{1'b0}};
            m_b_r       <= {OP_W{1'b0}};
        end else begin
            m_start_r <= 1'b0;
            ack_r     <= {NUM_REQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        gnt_r     <= pick_id_s;
                        m_a_r     <= a_in[int'(pick_id_s)*OP_W +: OP_W];
                        m_b_r     <= b_in[int'(pick_id_s)*OP_W +: OP_W];
                        m_start_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= LAUNCH;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                LAUNCH: begin
                    state_r <= ARM;
                end
                // A done still high from the previous operation must drop first.
                ARM: begin
                    if (tmo_hit_s) begin
                        result_r    <= {PROD_W{1'b0}};
                        result_id_r <= gnt_r;
                        ack_r       <= ONE_HOT0 << gnt_r;
                        state_r     <= DELIVER;
                    end else if (!m_done) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= ARM;
                    end
                end
                WAIT: begin
                    if (m_done) begin
                        result_r    <= m_product;
                        result_id_r <= gnt_r;
                        ack_r       <= ONE_HOT0 << gnt_r;
                        state_r     <= DELIVER;
                    end else if (tmo_hit_s) begin
                        result_r    <= {PROD_W{1'b0}};
                        result_id_r <= gnt_r;
                        ack_r       <= ONE_HOT0 << gnt_r;
                        state_r     <= DELIVER;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DELIVER: begin
                    ptr_r   <= rr_next(gnt_r, NUM_REQ);
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ack       = ack_r;
    assign result    = result_r;
    assign result_id = result_id_r;
    assign busy      = busy_r;
    assign m_start   = m_start_r;
    assign m_a       = m_a_r;
    assign m_b       = m_b_r;

endmodule
